sec_of_day_counter: RTL
=======================

SEC_OF_DAY_COUNTER -- requirements
Module: sec_of_day_counter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, clock cycles per second (legal range 2 or more).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port run  input  1  level; 1 = time advances, 0 = time frozen.
REQ-005 SHALL have port set_valid  input  1  load request, qualified by set_ready.
REQ-006 SHALL have port set_sec  input  17  value to load, seconds of day.
REQ-007 SHALL have port set_ready  output  1  load request may be accepted this cycle.
REQ-008 SHALL have port adj_hour  input  1  single-cycle pulse; add 3600 s.
REQ-009 SHALL have port adj_min  input  1  single-cycle pulse; add 60 s.
REQ-010 SHALL have port cur_sec  output  17  current seconds of day, 0..86399; feeds the hourly chime checker.
REQ-011 SHALL have port tick  output  1  one-cycle pulse on each 1 Hz advance of cur_sec.
REQ-012 SHALL have port day_wrap  output  1  one-cycle pulse when cur_sec wraps 86399->0 by a tick.
REQ-013 SHALL have port set_err  output  1  one-cycle pulse when an accepted set_sec is out of range.

Function
REQ-014 SHALL contain a prescaler counting 0..CLK_HZ-1 while in RUN; it wraps to 0 and asserts tick in the cycle it reaches CLK_HZ-1.
REQ-015 SHALL implement states STOP, RUN, LOAD: STOP->RUN when run=1; RUN->STOP when run=0; STOP/RUN->LOAD on accepted set; LOAD->RUN if run=1, otherwise LOAD->STOP, after exactly one cycle.
REQ-016 SHALL hold the prescaler value in STOP, so a pause followed by a resume does not lose partial-second progress.
REQ-017 SHALL drive set_ready=1 in STOP and RUN and set_ready=0 in LOAD; a set is accepted when set_valid=1 and set_ready=1.
REQ-018 SHALL, on acceptance with set_sec<=86399, make cur_sec equal set_sec on the next edge and clear the prescaler to 0.
REQ-019 SHALL, on acceptance with set_sec>=86400, leave cur_sec and the prescaler unchanged, pulse set_err for one cycle, and still enter LOAD.
REQ-020 SHALL, on a tick, update cur_sec <= (cur_sec==86399) ? 0 : cur_sec+1; day_wrap is asserted in the same cycle as that tick.
REQ-021 SHALL, on adj_hour, update cur_sec <= (cur_sec+3600) mod 86400, and on adj_min, update cur_sec <= (cur_sec+60) mod 86400; adjustments act in any state except LOAD and do not touch the prescaler or pulse day_wrap.
REQ-022 SHALL resolve simultaneous events within one cycle by priority: accepted set > adj_hour > adj_min > tick. A tick that coincides with a higher-priority event is dropped, but the prescaler still wraps.
REQ-023 SHALL compute all modulo arithmetic in at least 18 bits, so cur_sec never holds a value above 86399.
REQ-024 SHALL have tick, day_wrap and set_err all registered, each high for exactly one cycle per event.

Reset
REQ-025 SHALL, while rst_n=0, force asynchronously: state=STOP, prescaler=0, cur_sec=0, tick=0, day_wrap=0, set_err=0, set_ready=1.
REQ-026 SHALL, after rst_n deasserts mid-operation, resume only through STOP, with the first tick no earlier than CLK_HZ cycles after entering RUN.

Verification (CLK_HZ=4)
REQ-027 SHALL cover: reset, then run=1 for 12 cycles -> tick is high on cycles 4, 8 and 12 and cur_sec=3.
REQ-028 SHALL cover: set_sec=86398 accepted, then run for 8 cycles -> cur_sec=0, and day_wrap pulses once together with the 86399->0 tick.
REQ-029 SHALL cover: set_sec=90000 accepted while cur_sec=100 -> set_err pulses once, cur_sec stays 100, and set_ready=0 for one cycle.
REQ-030 SHALL cover: cur_sec=84000 with adj_hour pulsed -> cur_sec=1200; adj_hour and a tick in the same cycle at cur_sec=10 -> cur_sec=3610.
REQ-031 SHALL cover: run dropped after 2 prescaler counts and raised 10 cycles later -> the next tick occurs 2 cycles after resume.
REQ-032 SHALL cover: rst_n pulsed low mid-second with cur_sec=500 -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sec_of_day_counter.sv
// rtl/sec_of_day_counter.sv - seconds-of-day counter with prescaler, load and hour/minute adjust
module sec_of_day_counter #(
    parameter int CLK_HZ = 100000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        set_valid,
    input  logic [16:0] set_sec,
    output logic        set_ready,
    input  logic        adj_hour,
    input  logic        adj_min,
    output logic [16:0] cur_sec,
    output logic        tick,
    output logic        day_wrap,
    output logic        set_err
);

    localparam int              PW       = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]   PRE_MAX  = PW'(CLK_HZ - 1);
    localparam logic [17:0]     DAY_SECS = 18'd86400;
    localparam logic [16:0]     LAST_SEC = 17'd86399;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [PW-1:0]  pre, pre_nxt;
    logic [16:0]    sec_nxt;
    logic           tick_nxt, wrap_nxt, err_nxt;
    logic           active, accept, set_ok, pre_wrap;

    // Sum is formed in 18 bits so the single conditional subtract is exact.
    function automatic logic [16:0] wrap_add(input logic [16:0] a, input logic [17:0] b);
        logic [17:0] s;
        s = {1'b0, a} + b;
        if (s >= DAY_SECS)
            s = s - DAY_SECS;
        return s[16:0];
    endfunction

    always_comb begin
        active    = (state != ST_LOAD);
        set_ready = active;
        accept    = set_valid && active;
        set_ok    = ({1'b0, set_sec} < DAY_SECS);
        pre_wrap  = active && run && (pre == PRE_MAX);

        state_nxt = state;
        pre_nxt   = pre;
        sec_nxt   = cur_sec;
        tick_nxt  = 1'b0;
        wrap_nxt  = 1'b0;
        err_nxt   = 1'b0;

        case (state)
            ST_STOP: if (run)  state_nxt = ST_RUN;
            ST_RUN:  if (!run) state_nxt = ST_STOP;
            ST_LOAD: state_nxt = run ? ST_RUN : ST_STOP;
            default: state_nxt = ST_STOP;
        endcase

        if (active && run)
            pre_nxt = pre_wrap ? '0 : pre + 1'b1;

        // Priority: set > adj_hour > adj_min > tick; a losing tick still wraps the prescaler.
        if (accept) begin
            state_nxt = ST_LOAD;
            if (set_ok) begin
                sec_nxt = set_sec;
                pre_nxt = '0;
            end else begin
                err_nxt = 1'b1;
                pre_nxt = pre;
            end
        end else if (active && adj_hour) begin
            sec_nxt = wrap_add(cur_sec, 18'd3600);
        end else if (active && adj_min) begin
            sec_nxt = wrap_add(cur_sec, 18'd60);
        end else if (pre_wrap) begin
            tick_nxt = 1'b1;
            wrap_nxt = (cur_sec == LAST_SEC);
            sec_nxt  = (cur_sec == LAST_SEC) ? 17'd0 : cur_sec + 17'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_STOP;
            pre      <= '0;
            cur_sec  <= 17'd0;
            tick     <= 1'b0;
            day_wrap <= 1'b0;
            set_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            pre      <= pre_nxt;
            cur_sec  <= sec_nxt;
            tick     <= tick_nxt;
            day_wrap <= wrap_nxt;
            set_err  <= err_nxt;
        end
    end

endmodule
